// File: rtl/g15_tape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : g15_tape_pkg
// Description : Shared types and default timing for the phototape reader
//               emulator (reader states, frame type, timing constants).
// Revision    : 1.0 - initial release
// ============================================================================
package g15_tape_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FETCH = 3'd2,
    HOLE  = 3'd3,
    GAP   = 3'd4,
    EOT   = 3'd5
  } reader_state_t;

  typedef logic [4:0] frame_t;

  localparam int DEF_TAPE_DEPTH = 4096;
  localparam int DEF_START_CLKS = 200;
  localparam int DEF_HOLE_CLKS  = 40;
  localparam int DEF_GAP_CLKS   = 40;

  // Largest of the three timing intervals; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phototape_reader_emu_tape_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tape_buffer
// Description : Single-port synchronous tape image RAM, DEPTH x 5 bits, with
//               one write port and a registered read port on a shared address.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_buffer
  import g15_tape_pkg::*;
#(
  parameter int DEPTH = DEF_TAPE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  frame_t        wdata,
  output frame_t        rdata
);

  frame_t mem [DEPTH];

  // Storage has no reset: contents are meaningless until loaded by the host.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/phototape_reader_emu.sv
`default_nettype none
// ============================================================================
// Module      : phototape_reader_emu
// Description : Phototape reader emulator. Holds a host-loaded tape image and
//               plays it out on PHOTO1..5 under FWD/REV motion commands with
//               motor start delay, hole/gap timing and end-of-tape leader.
// Revision    : 1.0 - initial release
// ============================================================================
module phototape_reader_emu
  import g15_tape_pkg::*;
#(
  parameter int TAPE_DEPTH = DEF_TAPE_DEPTH,
  parameter int START_CLKS = DEF_START_CLKS,
  parameter int HOLE_CLKS  = DEF_HOLE_CLKS,
  parameter int GAP_CLKS   = DEF_GAP_CLKS
) (
  input  logic                          CLOCK,
  input  logic                          rst_n,
  input  logic                          PHOTO_TAPE_FWD,
  input  logic                          PHOTO_TAPE_REV,
  output logic                          PHOTO1,
  output logic                          PHOTO2,
  output logic                          PHOTO3,
  output logic                          PHOTO4,
  output logic                          PHOTO5,
  input  logic                          ld_clear,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [4:0]                    ld_data,
  input  logic                          rewind,
  output logic [$clog2(TAPE_DEPTH):0]   tape_len,
  output logic [$clog2(TAPE_DEPTH):0]   tape_pos,
  output logic                          moving,
  output logic                          at_end
);

  localparam int AW = $clog2(TAPE_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(max3(START_CLKS, HOLE_CLKS, GAP_CLKS) + 1);
  localparam logic [PW-1:0] DEPTH_L = PW'(TAPE_DEPTH);

  reader_state_t  state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           dir, dir_nxt;       // 1 = forward, latched when motion starts
  logic [PW-1:0]  len, pos;
  logic [PW-1:0]  pos_m1;
  logic           pos_inc, pos_dec;
  logic           idle, cmd, stop, wr_en, rd_en;
  logic [AW-1:0]  rd_addr, addr;
  frame_t         rd_data, photo;

  assign idle   = (state == IDLE);
  assign cmd    = PHOTO_TAPE_FWD ^ PHOTO_TAPE_REV;
  // A reversal while moving is handled exactly like a drop: back to IDLE,
  // then a fresh START in the new direction, so no frame is skipped.
  assign stop   = !cmd || (PHOTO_TAPE_FWD != dir);
  assign wr_en  = idle && ld_valid && !ld_clear && (len < DEPTH_L);
  assign rd_en  = (state == FETCH);
  assign pos_m1 = pos - 1'b1;
  assign rd_addr = dir ? pos[AW-1:0] : pos_m1[AW-1:0];
  assign addr    = wr_en ? len[AW-1:0] : rd_addr;

  tape_buffer #(
    .DEPTH (TAPE_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (CLOCK),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (addr),
    .wdata (ld_data),
    .rdata (rd_data)
  );

  // Next-state logic: motor delay, frame fetch, hole/gap timing, leader.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    pos_inc   = 1'b0;
    pos_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd) begin
          state_nxt = START;
          cnt_nxt   = CW'(START_CLKS - 1);
          dir_nxt   = PHOTO_TAPE_FWD;
        end
      end
      START: begin
        if (stop)          state_nxt = IDLE;
        else if (cnt == '0) state_nxt = FETCH;
        else               cnt_nxt   = cnt - 1'b1;
      end
      FETCH: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (dir ? (pos == len) : (pos == '0)) begin
          state_nxt = EOT;
        end else begin
          state_nxt = HOLE;
          cnt_nxt   = CW'(HOLE_CLKS - 1);
        end
      end
      HOLE: begin
        // A frame under the sensors always completes, even after a drop.
        if (cnt == '0) begin
          pos_inc   = dir;
          pos_dec   = !dir;
          state_nxt = stop ? IDLE : GAP;
          cnt_nxt   = CW'(GAP_CLKS - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (stop)          state_nxt = IDLE;
        else if (cnt == '0) state_nxt = FETCH;
        else               cnt_nxt   = cnt - 1'b1;
      end
      EOT: begin
        if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reader state, interval counter and latched direction.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  // Tape length and position; host clear/rewind only act while stopped.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
      pos <= '0;
    end else if (idle && ld_clear) begin
      len <= '0;
      pos <= '0;
    end else begin
      if (wr_en) len <= len + 1'b1;
      if (idle && rewind) pos <= '0;
      else if (pos_inc)   pos <= pos + 1'b1;
      else if (pos_dec)   pos <= pos_m1;
    end
  end

  assign photo = (state == HOLE) ? rd_data : '0;
  assign {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1} = photo;

  assign ld_ready = idle;
  assign moving   = !idle;
  assign tape_len = len;
  assign tape_pos = pos;
  assign at_end   = (pos == len);

endmodule
`default_nettype wire

// File: tb/tb_phototape_reader_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_phototape_reader_emu
// Description : Directed self-checking bench for the phototape reader emulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phototape_reader_emu;
  import g15_tape_pkg::*;

  localparam int D = 8;
  localparam int S = 10;
  localparam int H = 4;
  localparam int G = 3;

  logic       CLOCK = 1'b0;
  logic       rst_n = 1'b0;
  logic       PHOTO_TAPE_FWD = 1'b0, PHOTO_TAPE_REV = 1'b0;
  logic       PHOTO1, PHOTO2, PHOTO3, PHOTO4, PHOTO5;
  logic       ld_clear = 1'b0, ld_valid = 1'b0, rewind = 1'b0;
  logic       ld_ready, moving, at_end;
  logic [4:0] ld_data = '0;
  logic [3:0] tape_len, tape_pos;
  logic [4:0] photo;

  int pass  = 0;
  int total = 0;

  assign photo = {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1};

  phototape_reader_emu #(
    .TAPE_DEPTH (D), .START_CLKS (S), .HOLE_CLKS (H), .GAP_CLKS (G)
  ) dut (
    .CLOCK (CLOCK), .rst_n (rst_n),
    .PHOTO_TAPE_FWD (PHOTO_TAPE_FWD), .PHOTO_TAPE_REV (PHOTO_TAPE_REV),
    .PHOTO1 (PHOTO1), .PHOTO2 (PHOTO2), .PHOTO3 (PHOTO3),
    .PHOTO4 (PHOTO4), .PHOTO5 (PHOTO5),
    .ld_clear (ld_clear), .ld_valid (ld_valid), .ld_ready (ld_ready),
    .ld_data (ld_data), .rewind (rewind),
    .tape_len (tape_len), .tape_pos (tape_pos),
    .moving (moving), .at_end (at_end)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    total++; if ({photo, moving, ld_ready, at_end} !== {5'h00, 1'b0, 1'b1, 1'b1})
      $display("FAIL reset_flags: photo=%h moving=%b ready=%b at_end=%b want 00 0 1 1", photo, moving, ld_ready, at_end); else pass++;
    total++; if (tape_len !== 4'd0 || tape_pos !== 4'd0)
      $display("FAIL reset_len_pos: len=%0d pos=%0d want 0 0", tape_len, tape_pos); else pass++;
  endtask

  task automatic test_load3;
    logic [4:0] fr [3];
    fr = '{5'h01, 5'h10, 5'h1F};
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = fr[i];
      tick;
    end
    ld_valid = 1'b0;
    total++; if (tape_len !== 4'd3 || at_end !== 1'b0)
      $display("FAIL load3: len=%0d at_end=%b want 3 0", tape_len, at_end); else pass++;
  endtask

  task automatic test_forward;
    logic [4:0] exp [3];
    exp = '{5'h01, 5'h10, 5'h1F};
    PHOTO_TAPE_FWD = 1'b1;
    repeat (S + 1) tick;
    total++; if (photo !== 5'h00 || moving !== 1'b1 || ld_ready !== 1'b0)
      $display("FAIL fwd_pre_first: photo=%h moving=%b ready=%b want 00 1 0", photo, moving, ld_ready); else pass++;
    tick;
    for (int f = 0; f < 3; f++) begin
      for (int h = 0; h < H; h++) begin
        total++; if (photo !== exp[f])
          $display("FAIL fwd_hole f%0d h%0d: photo=%h want %h", f, h, photo, exp[f]); else pass++;
        tick;
      end
      for (int g = 0; g <= G; g++) begin
        total++; if (photo !== 5'h00)
          $display("FAIL fwd_gap f%0d g%0d: photo=%h want 00", f, g, photo); else pass++;
        if (g == 0) begin
          total++; if (tape_pos !== 4'(f + 1))
            $display("FAIL fwd_pos f%0d: pos=%0d want %0d", f, tape_pos, f + 1); else pass++;
        end
        tick;
      end
    end
    repeat (3) tick;
    total++; if (dut.state !== EOT || photo !== 5'h00 || tape_pos !== 4'd3 || at_end !== 1'b1)
      $display("FAIL fwd_eot: state=%0d photo=%h pos=%0d at_end=%b want EOT 00 3 1", dut.state, photo, tape_pos, at_end); else pass++;
  endtask

  task automatic test_reverse;
    logic [4:0] exp [3];
    exp = '{5'h1F, 5'h10, 5'h01};
    PHOTO_TAPE_FWD = 1'b0;
    tick;
    total++; if (moving !== 1'b0 || tape_pos !== 4'd3)
      $display("FAIL rev_stop: moving=%b pos=%0d want 0 3", moving, tape_pos); else pass++;
    PHOTO_TAPE_REV = 1'b1;
    repeat (S + 1) tick;
    total++; if (photo !== 5'h00)
      $display("FAIL rev_pre_first: photo=%h want 00", photo); else pass++;
    tick;
    for (int f = 0; f < 3; f++) begin
      for (int h = 0; h < H; h++) begin
        total++; if (photo !== exp[f])
          $display("FAIL rev_hole f%0d h%0d: photo=%h want %h", f, h, photo, exp[f]); else pass++;
        tick;
      end
      for (int g = 0; g <= G; g++) begin
        if (g == 0) begin
          total++; if (tape_pos !== 4'(2 - f))
            $display("FAIL rev_pos f%0d: pos=%0d want %0d", f, tape_pos, 2 - f); else pass++;
        end
        tick;
      end
    end
    tick;
    total++; if (dut.state !== EOT || photo !== 5'h00 || tape_pos !== 4'd0)
      $display("FAIL rev_eot: state=%0d photo=%h pos=%0d want EOT 00 0", dut.state, photo, tape_pos); else pass++;
    PHOTO_TAPE_REV = 1'b0;
    tick;
  endtask

  task automatic test_drop_mid_hole;
    PHOTO_TAPE_FWD = 1'b1;
    repeat (S + 2) tick;
    repeat (H + G + 1) tick;
    total++; if (photo !== 5'h10 || tape_pos !== 4'd1)
      $display("FAIL drop_frame2_start: photo=%h pos=%0d want 10 1", photo, tape_pos); else pass++;
    tick;
    PHOTO_TAPE_FWD = 1'b0;
    for (int h = 1; h < H; h++) begin
      total++; if (photo !== 5'h10)
        $display("FAIL drop_hole h%0d: photo=%h want 10", h, photo); else pass++;
      tick;
    end
    total++; if (photo !== 5'h00 || tape_pos !== 4'd2 || ld_ready !== 1'b1 || moving !== 1'b0)
      $display("FAIL drop_idle: photo=%h pos=%0d ready=%b moving=%b want 00 2 1 0", photo, tape_pos, ld_ready, moving); else pass++;
  endtask

  task automatic test_both_cmds;
    int bad;
    bad = 0;
    PHOTO_TAPE_FWD = 1'b1; PHOTO_TAPE_REV = 1'b1;
    repeat (1000) begin
      tick;
      if (moving !== 1'b0 || photo !== 5'h00) bad++;
    end
    PHOTO_TAPE_FWD = 1'b0; PHOTO_TAPE_REV = 1'b0;
    total++; if (bad !== 0)
      $display("FAIL both_cmds_idle: %0d cycles moving or lit, want 0", bad); else pass++;
    total++; if (tape_pos !== 4'd2)
      $display("FAIL both_cmds_pos: pos=%0d want 2", tape_pos); else pass++;
    rewind = 1'b1;
    tick;
    rewind = 1'b0;
    total++; if (tape_pos !== 4'd0)
      $display("FAIL rewind: pos=%0d want 0", tape_pos); else pass++;
  endtask

  task automatic test_load_limit;
    ld_clear = 1'b1;
    tick;
    ld_clear = 1'b0;
    total++; if (tape_len !== 4'd0)
      $display("FAIL clear: len=%0d want 0", tape_len); else pass++;
    ld_valid = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      ld_data = 5'(i);
      tick;
    end
    ld_valid = 1'b0;
    total++; if (tape_len !== 4'(D) || ld_ready !== 1'b1)
      $display("FAIL full_len: len=%0d ready=%b want %0d 1", tape_len, ld_ready, D); else pass++;
    ld_valid = 1'b1; ld_clear = 1'b1;
    tick;
    ld_valid = 1'b0; ld_clear = 1'b0;
    total++; if (tape_len !== 4'd0)
      $display("FAIL clear_priority: len=%0d want 0", tape_len); else pass++;
    test_load3;
    PHOTO_TAPE_FWD = 1'b1;
    repeat (2) tick;
    total++; if (ld_ready !== 1'b0 || moving !== 1'b1)
      $display("FAIL moving_ready: ready=%b moving=%b want 0 1", ld_ready, moving); else pass++;
    ld_valid = 1'b1; ld_data = 5'h07;
    tick;
    ld_valid = 1'b0;
    total++; if (tape_len !== 4'd3)
      $display("FAIL moving_write: len=%0d want 3", tape_len); else pass++;
    PHOTO_TAPE_FWD = 1'b0;
    tick;
  endtask

  task automatic test_async_reset;
    PHOTO_TAPE_FWD = 1'b1;
    repeat (S + 2) tick;
    total++; if (photo !== 5'h01)
      $display("FAIL reload_frame1: photo=%h want 01", photo); else pass++;
    repeat (H + G + 1) tick;
    repeat (H) tick;
    total++; if (tape_pos !== 4'd2 || photo !== 5'h00 || moving !== 1'b1)
      $display("FAIL gap_setup: pos=%0d photo=%h moving=%b want 2 00 1", tape_pos, photo, moving); else pass++;
    rst_n = 1'b0;
    #1;
    total++; if (photo !== 5'h00 || moving !== 1'b0 || tape_len !== 4'd0 || tape_pos !== 4'd0 || at_end !== 1'b1)
      $display("FAIL async_reset: photo=%h moving=%b len=%0d pos=%0d at_end=%b want 00 0 0 0 1", photo, moving, tape_len, tape_pos, at_end); else pass++;
    PHOTO_TAPE_FWD = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_load3;
    test_forward;
    test_reverse;
    test_drop_mid_hole;
    test_both_cmds;
    test_load_limit;
    test_async_reset;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phototape_reader_emu.md
Name: phototape_reader_emu

Overview:
- Emulates the built-in phototape reader: the peripheral end of the PHOTO_TAPE_FWD/REV → PHOTO1..5 interface of the I/O section.
- Holds a tape image loaded by a host port; it presents one 5-bit frame per frame period while the I/O section commands motion.
- Models motor start delay, hole/gap timing, and end-of-tape/leader behaviour, so io_top can be exercised without physical hardware.

Parameters:
- TAPE_DEPTH, 4096, tape image capacity in frames (power of 2).
- START_CLKS, 200, clocks from motion command to first frame (motor/clutch delay).
- HOLE_CLKS, 40, clocks a frame is driven on PHOTO1..5.
- GAP_CLKS, 40, clocks of all-zero inter-frame gap.

Ports:
- CLOCK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- PHOTO_TAPE_FWD  in  1  forward motion command from I/O section.
- PHOTO_TAPE_REV  in  1  reverse motion command from I/O section.
- PHOTO1..PHOTO5  out  1 each  sensed holes of the current frame (PHOTO1 = LSB).
- ld_clear  in  1  host pulse: empty tape, len=0, pos=0.
- ld_valid  in  1  host frame write strobe.
- ld_ready  out  1  host may write (reader stopped).
- ld_data  in  5  frame to append at address len.
- rewind  in  1  host pulse: pos=0 (ignored while moving).
- tape_len  out  $clog2(TAPE_DEPTH)+1  frames loaded.
- tape_pos  out  $clog2(TAPE_DEPTH)+1  index of next frame in current direction.
- moving  out  1  state ≠ IDLE.
- at_end  out  1  pos==len.

Behaviour:
- Reset values: PHOTO1..5=0, state=IDLE, len=0, pos=0, ld_ready=1, moving=0, at_end=1.
- Direction decode: cmd = FWD^REV; dir = FWD. Both asserted or neither asserted means stop.
- States:
  - IDLE: PHOTO=0, ld_ready=1. On cmd → START with counter=START_CLKS-1.
  - START: counts down; PHOTO=0.
    - At 0 → FETCH.
  - FETCH (1 clk): issues the buffer read.
    - FWD: address pos. If pos==len → EOT.
    - REV: address pos-1. If pos==0 → EOT.
  - HOLE: PHOTO=read data (valid one clock after FETCH, registered) for HOLE_CLKS clocks.
    - FWD: pos++ at the last HOLE clock.
    - REV: pos-- at the last HOLE clock.
    - Then → GAP.
  - GAP: PHOTO=0 for GAP_CLKS clocks, then → FETCH.
  - EOT: PHOTO=0 (blank leader), stays until cmd drops.
- Command drop (cmd=0) in START/FETCH/GAP/EOT → IDLE on the next clock, PHOTO=0.
  - Drop during HOLE completes the current frame (pos updates), then → IDLE.
- Direction change while moving: treated as drop followed by a new command. The reader returns to IDLE, then START again with no frame skipped.
- Load path: a write occurs when ld_valid & ld_ready & len<TAPE_DEPTH. It writes ld_data at len, then len++. Writes at len==TAPE_DEPTH are dropped silently.
  - ld_ready=0 whenever moving.
  - ld_clear takes priority over ld_valid in the same clock.
- Frame timing from first command clock, forward: first PHOTO data appears START_CLKS+2 clocks later. Frame period is HOLE_CLKS+GAP_CLKS+1.
- Counter widths: sized from max(START_CLKS,HOLE_CLKS,GAP_CLKS). pos and len never wrap.
- Asynchronous reset mid-frame: everything returns to reset values immediately. Tape contents are undefined (len=0).
- All inputs are synchronous to CLOCK; FWD/REV come from io_top logic in the same domain, so there is no synchroniser.

Decomposition:
- Package g15_tape_pkg:
  - reader state enum (IDLE, START, FETCH, HOLE, GAP, EOT).
  - frame_t (logic [4:0]).
  - default timing constants.
- Sub-module tape_buffer:
  - single-port synchronous RAM, TAPE_DEPTH×5.
  - one write port and one registered read port, sharing an address mux (write only when IDLE).

Test Plan:
- Load 3 frames {5'h01,5'h10,5'h1F}, hold FWD. Required: PHOTO shows 01, 10, 1F in order, each HOLE_CLKS wide with GAP_CLKS zeros between. The first frame appears at START_CLKS+2. After the third frame, state=EOT, PHOTO=0, tape_pos=3, at_end=1.
- From pos=3, drop FWD, then assert REV. Required: frames 1F, 10, 01 in that order, then EOT with tape_pos=0.
- Drop FWD mid-HOLE of frame 2 (pos=1). Required: frame 5'h10 completes its full HOLE_CLKS, tape_pos=2, then IDLE with PHOTO=0 and ld_ready=1.
- Assert FWD and REV together from IDLE for 1000 clocks. Required: moving=0, PHOTO=0, tape_pos unchanged.
- Write TAPE_DEPTH+2 frames. Required: tape_len=TAPE_DEPTH and the extra writes are ignored. Then ld_valid and ld_clear together → tape_len=0. While moving, ld_ready=0 and a pulsed ld_valid leaves len unchanged.
- Deassert rst_n during GAP with pos=2. Required: PHOTO1..5=0, tape_len=0, tape_pos=0, moving=0 asynchronously, before the next CLOCK edge.
